// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction-SRAM responder with 1-cycle read latency, byte-lane writes and preload port
module inst_sram_responder #(
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sram_en,
    input  logic [3:0]            sram_we,
    input  logic [31:0]           sram_addr,
    input  logic [31:0]           sram_wdata,
    output logic [31:0]           sram_rdata,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  oob_err,
    output logic                  collide,
    output logic [31:0]           rd_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  accepted;
    logic                  is_write;
    logic                  load_hit;
    logic                  store;

    always_comb begin
        off      = sram_addr - BASE_ADDR;
        idx      = off[ADDR_WIDTH+1:2];
        in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;
        accepted = resetn && sram_en;
        is_write = |sram_we;
        load_hit = load_en && (load_addr == idx);
        // A same-index preload always wins; the sram write is dropped whole.
        store    = accepted && is_write && in_range && !load_hit;
    end

    // Preload runs regardless of reset so memory can be filled with the core held off.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (store) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) begin
                    mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sram_rdata <= RESET_RDATA;
            oob_err    <= 1'b0;
            collide    <= 1'b0;
            rd_count   <= 32'd0;
        end else if (accepted) begin
            sram_rdata <= in_range ? mem[idx] : 32'h0;
            if (!in_range) begin
                oob_err <= 1'b1;
            end
            if (is_write && in_range && load_hit) begin
                collide <= 1'b1;
            end
            if (!is_write && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb/tb_inst_sram_responder.sv - scoreboard bench for inst_sram_responder
module tb_inst_sram_responder;

    localparam int          AW    = 16;
    localparam logic [31:0] BASE  = 32'h1C00_0000;
    localparam logic [31:0] RST_D = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sram_en = 1'b0;
    logic [3:0]    sram_we = 4'h0;
    logic [31:0]   sram_addr = 32'h0;
    logic [31:0]   sram_wdata = 32'h0;
    logic [31:0]   sram_rdata;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = 32'h0;
    logic          oob_err;
    logic          collide;
    logic [31:0]   rd_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = RST_D;
    logic        mon_fire;
    logic        mon_rst;

    inst_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RESET_RDATA(RST_D)) dut (
        .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .oob_err(oob_err), .collide(collide), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every edge either presents reset data, a new response, or held data.
    always @(posedge clk) begin
        mon_fire = sram_en && resetn;
        mon_rst  = !resetn;
        #2;
        if (mon_rst) begin
            last_exp = RST_D;
            chk("rdata_reset", sram_rdata, last_exp);
        end else if (mon_fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got response %h expected none queued", sram_rdata);
            end else begin
                last_exp = exp_q.pop_front();
                chk("rdata", sram_rdata, last_exp);
            end
        end else begin
            chk("rdata_hold", sram_rdata, last_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        sram_en = 1'b0;
        sram_we = 4'h0;
        load_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        sram_en = 1'b1; sram_we = 4'h0; sram_addr = addr;
        exp_q.push_back(exp);
        step();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] d, input logic [31:0] exp);
        sram_en = 1'b1; sram_we = we; sram_addr = addr; sram_wdata = d;
        exp_q.push_back(exp);
        step();
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
    endtask

    initial begin
        #1;
        // 1: preload under reset, then back-to-back reads
        ld(16'd0, 32'h0280_0400);
        ld(16'd1, 32'h1C00_000C);
        chk("rd_count_reset", rd_count, 32'd0);
        chk("oob_reset", {31'd0, oob_err}, 32'd0);
        chk("collide_reset", {31'd0, collide}, 32'd0);
        resetn = 1'b1;
        rd(BASE, 32'h0280_0400);
        rd(BASE + 32'd4, 32'h1C00_000C);
        chk("rd_count_t1", rd_count, 32'd2);
        // 2: data held across idle cycles
        rd(BASE + 32'd4, 32'h1C00_000C);
        step(); step(); step();
        chk("rd_count_t2", rd_count, 32'd3);
        // 3: byte-lane write returns the pre-write word
        ld(16'd2, 32'h1122_3344);
        wr(BASE + 32'd8, 4'b0101, 32'hAABB_CCDD, 32'h1122_3344);
        rd(BASE + 32'd8, 32'h11BB_33DD);
        chk("rd_count_t3", rd_count, 32'd4);
        // 4: last mapped word is in range; either side of the window is not
        ld(16'hFFFF, 32'h5A5A_A5A5);
        rd(BASE + 32'h0003_FFFC, 32'h5A5A_A5A5);
        chk("oob_edge_in", {31'd0, oob_err}, 32'd0);
        rd(32'h1BFF_FFFC, 32'h0);
        chk("oob_below", {31'd0, oob_err}, 32'd1);
        rd(BASE + 32'h0004_0000, 32'h0);
        rd(BASE, 32'h0280_0400);
        chk("oob_sticky", {31'd0, oob_err}, 32'd1);
        chk("rd_count_t4", rd_count, 32'd8);
        // 5: load and sram write collide on idx3
        ld(16'd3, 32'h1234_5678);
        chk("collide_before", {31'd0, collide}, 32'd0);
        load_en = 1'b1; load_addr = 16'd3; load_data = 32'hDEAD_BEEF;
        wr(BASE + 32'hC, 4'hF, 32'h0000_0001, 32'h1234_5678);
        chk("collide_set", {31'd0, collide}, 32'd1);
        rd(BASE + 32'hC, 32'hDEAD_BEEF);
        // read vs load on the same index is read-first
        load_en = 1'b1; load_addr = 16'd1; load_data = 32'hCAFE_F00D;
        rd(BASE + 32'd4, 32'h1C00_000C);
        rd(BASE + 32'd4, 32'hCAFE_F00D);
        chk("collide_sticky", {31'd0, collide}, 32'd1);
        chk("rd_count_t5", rd_count, 32'd11);
        // 6: read in the reset cycle is discarded; memory survives reset
        resetn = 1'b0; sram_en = 1'b1; sram_we = 4'h0; sram_addr = BASE + 32'd8;
        step();
        chk("rd_count_mid_reset", rd_count, 32'd0);
        chk("oob_mid_reset", {31'd0, oob_err}, 32'd0);
        chk("collide_mid_reset", {31'd0, collide}, 32'd0);
        resetn = 1'b1;
        step();
        rd(BASE, 32'h0280_0400);
        rd(BASE + 32'hC, 32'hDEAD_BEEF);
        chk("rd_count_t6", rd_count, 32'd2);
        step(); step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
